// File: rtl/usb2_ep_tx_feeder_if.sv
// Endpoint-buffer / TX-framer / token-decoder signals seen by usb2_ep_tx_feeder.
// master is the feeder's view; slave is the surrounding endpoint, framer and token logic.
interface usb2_ep_tx_feeder_if;
    logic       in_token;
    logic       resp_nak;
    logic       resp_data;
    logic       ep_hasdata;
    logic [9:0] ep_len;
    logic [8:0] ep_addr;
    logic [7:0] ep_q;
    logic       ep_arm;
    logic       ep_arm_ack;
    logic       toggle_act;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       hs_ack;

    modport master (
        input  in_token, ep_hasdata, ep_len, ep_q, ep_arm_ack, tx_ready, hs_ack,
        output resp_nak, resp_data, ep_addr, ep_arm, toggle_act, tx_data, tx_valid, tx_last
    );

    modport slave (
        output in_token, ep_hasdata, ep_len, ep_q, ep_arm_ack, tx_ready, hs_ack,
        input  resp_nak, resp_data, ep_addr, ep_arm, toggle_act, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/usb2_ep_tx_feeder.sv
// Streams one endpoint buffer half to the USB TX framer per IN token, then arms it after the handshake.
// Define USB2_EP_TX_RETRY_EN to replay the half after a handshake timeout instead of releasing it.
module usb2_ep_tx_feeder #(
    parameter int MAX_PKT    = 512,
    parameter int HS_TIMEOUT = 816
) (
    input  logic                    phy_clk,
    input  logic                    reset,
    usb2_ep_tx_feeder_if.master     bus
);

    localparam int                 CNT_W   = $clog2(HS_TIMEOUT);
    localparam logic [9:0]         MAX_LEN = 10'(MAX_PKT);
    localparam logic [CNT_W-1:0]   HS_LAST = CNT_W'(HS_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RESP, FETCH, STREAM, WAIT_HS, ARM, ARM_WAIT} state_t;

    state_t           state_reg;
    logic [9:0]       len_reg;
    logic [9:0]       issued_reg;
    logic [8:0]       ep_addr_reg;
    logic             rd_pend_reg;
    logic             rd_last_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_valid_reg;
    logic             tx_last_reg;
    logic [7:0]       skid_data_reg;
    logic             skid_valid_reg;
    logic             skid_last_reg;
    logic             resp_nak_reg;
    logic             resp_data_reg;
    logic             ep_arm_reg;
    logic             toggle_act_reg;
    logic [CNT_W-1:0] hs_cnt_reg;

    logic       streaming;
    logic       tx_accept;
    logic       out_free;
    logic [1:0] occ_after;
    logic       can_issue;
    logic [9:0] len_clamped;

    assign streaming   = (state_reg == FETCH) || (state_reg == STREAM);
    assign tx_accept   = tx_valid_reg & bus.tx_ready;
    assign out_free    = tx_accept | ~tx_valid_reg;
    // Bytes held after this edge; a read issued now lands one cycle later, so at most one may remain.
    assign occ_after   = {1'b0, tx_valid_reg} + {1'b0, skid_valid_reg}
                       + {1'b0, rd_pend_reg} - {1'b0, tx_accept};
    assign can_issue   = streaming && (issued_reg != len_reg) && (occ_after <= 2'd1);
    assign len_clamped = (bus.ep_len > MAX_LEN) ? MAX_LEN : bus.ep_len;

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            issued_reg     <= '0;
            ep_addr_reg    <= '0;
            rd_pend_reg    <= 1'b0;
            rd_last_reg    <= 1'b0;
            tx_data_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            tx_last_reg    <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_last_reg  <= 1'b0;
            resp_nak_reg   <= 1'b0;
            resp_data_reg  <= 1'b0;
            ep_arm_reg     <= 1'b0;
            toggle_act_reg <= 1'b0;
            hs_cnt_reg     <= '0;
        end else begin
            resp_nak_reg   <= 1'b0;
            resp_data_reg  <= 1'b0;
            toggle_act_reg <= 1'b0;

            if (can_issue) begin
                ep_addr_reg <= ep_addr_reg + 9'd1;
                issued_reg  <= issued_reg + 10'd1;
            end
            rd_pend_reg <= can_issue;
            rd_last_reg <= can_issue && (issued_reg == len_reg - 10'd1);

            // Output register refills from the skid entry first to keep address order.
            if (out_free) begin
                if (skid_valid_reg) begin
                    tx_data_reg    <= skid_data_reg;
                    tx_valid_reg   <= 1'b1;
                    tx_last_reg    <= skid_last_reg;
                    skid_valid_reg <= rd_pend_reg;
                    skid_data_reg  <= bus.ep_q;
                    skid_last_reg  <= rd_last_reg;
                end else if (rd_pend_reg) begin
                    tx_data_reg  <= bus.ep_q;
                    tx_valid_reg <= 1'b1;
                    tx_last_reg  <= rd_last_reg;
                end else begin
                    tx_valid_reg <= 1'b0;
                    tx_last_reg  <= 1'b0;
                end
            end else if (rd_pend_reg) begin
                skid_data_reg  <= bus.ep_q;
                skid_valid_reg <= 1'b1;
                skid_last_reg  <= rd_last_reg;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.in_token) begin
                        len_reg <= len_clamped;
                        if (!bus.ep_hasdata) begin
                            resp_nak_reg <= 1'b1;
                        end else begin
                            resp_data_reg <= 1'b1;
                            state_reg     <= RESP;
                        end
                    end
                end
                RESP: begin
                    ep_addr_reg <= '0;
                    issued_reg  <= '0;
                    hs_cnt_reg  <= '0;
                    state_reg   <= (len_reg == 10'd0) ? WAIT_HS : FETCH;
                end
                FETCH: state_reg <= STREAM;
                STREAM: begin
                    if (tx_accept && tx_last_reg) begin
                        hs_cnt_reg <= '0;
                        state_reg  <= WAIT_HS;
                    end
                end
                WAIT_HS: begin
                    if (bus.hs_ack) begin
                        toggle_act_reg <= 1'b1;
                        state_reg      <= ARM;
                    end else if (hs_cnt_reg == HS_LAST) begin
`ifdef USB2_EP_TX_RETRY_EN
                        state_reg <= IDLE;
`else
                        toggle_act_reg <= 1'b1;
                        state_reg      <= ARM;
`endif
                    end else begin
                        hs_cnt_reg <= hs_cnt_reg + 1'b1;
                    end
                end
                ARM: begin
                    // Hold the request until the endpoint's synchronised ack shows up.
                    if (bus.ep_arm_ack) begin
                        ep_arm_reg <= 1'b0;
                        state_reg  <= ARM_WAIT;
                    end else begin
                        ep_arm_reg <= 1'b1;
                    end
                end
                ARM_WAIT: begin
                    ep_arm_reg <= 1'b0;
                    if (!bus.ep_arm_ack) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.resp_nak   = resp_nak_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.ep_addr    = ep_addr_reg;
    assign bus.ep_arm     = ep_arm_reg;
    assign bus.toggle_act = toggle_act_reg;
    assign bus.tx_data    = tx_data_reg;
    assign bus.tx_valid   = tx_valid_reg;
    assign bus.tx_last    = tx_last_reg;

endmodule

// File: tb/tb_usb2_ep_tx_feeder.sv
// Scoreboard bench for usb2_ep_tx_feeder: endpoint RAM/arm model, random tx_ready, timeout and reset cases.
module tb_usb2_ep_tx_feeder;
    localparam int MAX_PKT    = 512;
    localparam int HS_TIMEOUT = 816;

    logic phy_clk = 1'b0;
    logic reset   = 1'b1;

    usb2_ep_tx_feeder_if bus();

    usb2_ep_tx_feeder #(.MAX_PKT(MAX_PKT), .HS_TIMEOUT(HS_TIMEOUT)) dut (
        .phy_clk (phy_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 phy_clk = ~phy_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Endpoint RAM: one-cycle registered read
    logic [7:0] mem [0:511];
    always @(posedge phy_clk) bus.ep_q <= mem[bus.ep_addr];

    logic [8:0] exp_q[$];
    int  bytes_seen = 0, arm_cnt = 0, tog_cnt = 0, nak_cnt = 0, dat_cnt = 0;
    bit  rand_ready = 1'b0;

    // Output monitor / scoreboard consumer
    initial begin
        logic       prev_arm;
        logic       hold_pending;
        logic [8:0] hold_val;
        logic [8:0] e;
        prev_arm = 1'b0;
        hold_pending = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge phy_clk);
            if (hold_pending && !reset) begin
                check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
                check("hold_byte", {23'd0, bus.tx_last, bus.tx_data}, {23'd0, hold_val});
            end
            hold_pending = bus.tx_valid && !bus.tx_ready;
            hold_val     = {bus.tx_last, bus.tx_data};
            if (bus.tx_valid && bus.tx_ready) begin
                bytes_seen++;
                if (exp_q.size() == 0) begin
                    check("extra_byte", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {23'd0, bus.tx_last, bus.tx_data}, {23'd0, e});
                end
            end
            if (bus.ep_arm && !prev_arm) arm_cnt++;
            prev_arm = bus.ep_arm;
            if (bus.toggle_act) tog_cnt++;
            if (bus.resp_nak)   nak_cnt++;
            if (bus.resp_data)  dat_cnt++;
        end
    end

    // Framer back-pressure
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge phy_clk); #1;
            bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Endpoint arm acknowledge with 3-cycle synchroniser delay
    initial begin
        int dly;
        dly = 0;
        bus.ep_arm_ack = 1'b0;
        forever begin
            @(posedge phy_clk); #2;
            if (bus.ep_arm && !bus.ep_arm_ack) begin
                dly++;
                if (dly >= 3) begin bus.ep_arm_ack = 1'b1; dly = 0; end
            end else if (!bus.ep_arm && bus.ep_arm_ack) begin
                dly++;
                if (dly >= 2) begin bus.ep_arm_ack = 1'b0; dly = 0; end
            end else begin
                dly = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge phy_clk); #1;
    endtask

    task automatic prep(input int len_in, input int base, input int step);
        int n;
        for (int i = 0; i < 512; i++) mem[i] = 8'(base + i * step);
        bus.ep_hasdata = 1'b1;
        bus.ep_len     = 10'(len_in);
        n = (len_in > MAX_PKT) ? MAX_PKT : len_in;
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mem[i]});
    endtask

    task automatic stream_packet(input int n, input int done_tick);
        int b0, d0;
        bit ok;
        b0 = bytes_seen;
        d0 = dat_cnt;
        ok = 1'b0;
        bus.in_token = 1'b1;
        tick();
        bus.in_token = 1'b0;
        check("resp_data", {31'd0, bus.resp_data}, 32'd1);
        for (int t = 1; t <= 4000; t++) begin
            tick();
            if (done_tick > 0 && t == 2) check("lat_pre", {31'd0, bus.tx_valid}, 32'd0);
            if (done_tick > 0 && t == 3) check("lat_first", {31'd0, bus.tx_valid}, 32'd1);
            if (done_tick > 0 && t == done_tick) begin
                check("burst_bytes", bytes_seen - b0, n);
                check("burst_gap", {31'd0, bus.tx_valid}, 32'd0);
            end
            if (t == 10) bus.in_token = 1'b1;
            if (t == 11) bus.in_token = 1'b0;
            if (t >= 12 && exp_q.size() == 0 && !bus.tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", {31'd0, ok}, 32'd1);
        check("byte_count", bytes_seen - b0, n);
        check("resp_once", dat_cnt - d0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (!bus.ep_arm && !bus.ep_arm_ack) begin ok = 1'b1; break; end
        end
        check("arm_release", {31'd0, ok}, 32'd1);
        tick();
        tick();
    endtask

    task automatic handshake(input int dly);
        int t0, a0;
        t0 = tog_cnt;
        a0 = arm_cnt;
        repeat (dly) tick();
        bus.hs_ack = 1'b1;
        tick();
        bus.hs_ack = 1'b0;
        check("toggle_act", {31'd0, bus.toggle_act}, 32'd1);
        tick();
        check("toggle_pulse", {31'd0, bus.toggle_act}, 32'd0);
        check("ep_arm", {31'd0, bus.ep_arm}, 32'd1);
        wait_idle();
        check("toggle_cnt", tog_cnt - t0, 32'd1);
        check("arm_cnt", arm_cnt - a0, 32'd1);
    endtask

    initial begin
        int b0, a0, t0;
        bus.in_token   = 1'b0;
        bus.hs_ack     = 1'b0;
        bus.ep_hasdata = 1'b0;
        bus.ep_len     = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;

        reset = 1'b1;
        repeat (3) tick();
        check("rst_tx_valid",  {31'd0, bus.tx_valid},   32'd0);
        check("rst_tx_last",   {31'd0, bus.tx_last},    32'd0);
        check("rst_tx_data",   {24'd0, bus.tx_data},    32'd0);
        check("rst_ep_addr",   {23'd0, bus.ep_addr},    32'd0);
        check("rst_ep_arm",    {31'd0, bus.ep_arm},     32'd0);
        check("rst_resp_nak",  {31'd0, bus.resp_nak},   32'd0);
        check("rst_resp_data", {31'd0, bus.resp_data},  32'd0);
        check("rst_toggle",    {31'd0, bus.toggle_act}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // NAK when the endpoint is empty
        b0 = bytes_seen;
        a0 = arm_cnt;
        bus.in_token = 1'b1;
        tick();
        bus.in_token = 1'b0;
        check("resp_nak", {31'd0, bus.resp_nak}, 32'd1);
        check("nak_no_data", {31'd0, bus.resp_data}, 32'd0);
        tick();
        check("nak_pulse", {31'd0, bus.resp_nak}, 32'd0);
        repeat (5) tick();
        check("nak_no_bytes", bytes_seen - b0, 32'd0);
        check("nak_no_arm", arm_cnt - a0, 32'd0);
        check("nak_cnt", nak_cnt, 32'd1);

        // Five bytes back to back
        prep(5, 8'h10, 1);
        stream_packet(5, 8);
        handshake(10);

        // hs_ack while idle is ignored
        t0 = tog_cnt;
        bus.hs_ack = 1'b1;
        tick();
        bus.hs_ack = 1'b0;
        repeat (3) tick();
        check("hs_ignored", tog_cnt - t0, 32'd0);

        // 64 bytes with random back-pressure
        rand_ready = 1'b1;
        prep(64, 8'h40, 5);
        stream_packet(64, 0);
        rand_ready = 1'b0;
        handshake(4);

        // Zero-length packet
        prep(0, 0, 1);
        stream_packet(0, 0);
        handshake(3);

        // Oversize length clamps to MAX_PKT
        prep(700, 8'h80, 1);
        stream_packet(512, 0);
        handshake(2);

        // Handshake timeout
        prep(3, 8'hA0, 7);
        t0 = tog_cnt;
        a0 = arm_cnt;
        stream_packet(3, 0);
        repeat (HS_TIMEOUT + 100) tick();
`ifdef USB2_EP_TX_RETRY_EN
        check("to_no_toggle", tog_cnt - t0, 32'd0);
        check("to_no_arm", arm_cnt - a0, 32'd0);
        prep(3, 8'hA0, 7);
        stream_packet(3, 0);
        handshake(5);
`else
        check("to_toggle", tog_cnt - t0, 32'd1);
        check("to_arm", arm_cnt - a0, 32'd1);
        check("to_idle_arm", {31'd0, bus.ep_arm}, 32'd0);
`endif

        // Reset in the middle of a packet
        prep(64, 8'h33, 1);
        a0 = arm_cnt;
        bus.in_token = 1'b1;
        tick();
        bus.in_token = 1'b0;
        repeat (10) tick();
        check("pre_rst_valid", {31'd0, bus.tx_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("mid_rst_last",  {31'd0, bus.tx_last},  32'd0);
        check("mid_rst_arm",   {31'd0, bus.ep_arm},   32'd0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst_no_arm", arm_cnt - a0, 32'd0);

        // The same half replays from address 0
        prep(64, 8'h33, 1);
        stream_packet(64, 0);
        handshake(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
